// File: rtl/bcd_bin_shiftsub3.sv
// Sequential BCD-to-binary converter (reverse double-dabble: shift right, subtract 3).
// Optional digit validity check: define BCDBIN_ERRCHK_EN to enable the error path.
// Without it, err is tied low and every accepted start runs the full BINW iterations.
module bcd_bin_shiftsub3 #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BINW   = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcdin,
    output logic [BINW-1:0]     bindata,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int unsigned   BcdW    = 4 * DIGITS;
    localparam int unsigned   CntW    = $clog2(BINW + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(BINW - 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(BINW);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e               state_q, state_d;
    logic [BcdW-1:0]      bcd_q, bcd_d;
    logic [BINW-1:0]      bin_q, bin_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [BINW-1:0]      bindata_q, bindata_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [BcdW+BINW-1:0] shifted;
    logic [BcdW-1:0]      adj_bcd;

`ifdef BCDBIN_ERRCHK_EN
    logic                 bad_digit;
    logic                 errp_q, errp_d;
    logic                 err_q, err_d;

    // Flag any input digit above 9; only consulted when start is accepted.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcdin[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // One iteration: shift {bcd, bin} right, then pull each digit >= 8 down by 3.
    always_comb begin
        shifted = {bcd_q, bin_q} >> 1;
        adj_bcd = shifted[BINW +: BcdW];
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (adj_bcd[4*i +: 4] >= 4'd8) adj_bcd[4*i +: 4] = adj_bcd[4*i +: 4] - 4'd3;
        end
    end

    // Next-state and registered-output logic for the IDLE -> CONV -> DONE sequence.
    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        bindata_d = bindata_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
`ifdef BCDBIN_ERRCHK_EN
        errp_d    = errp_q;
        err_d     = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    bcd_d = bcdin;
                    bin_d = '0;
                    cnt_d = '0;
`ifdef BCDBIN_ERRCHK_EN
                    errp_d = bad_digit;
                    if (bad_digit) begin
                        state_d = StDone;
                    end else begin
                        state_d = StConv;
                        busy_d  = 1'b1;
                    end
`else
                    state_d = StConv;
                    busy_d  = 1'b1;
`endif
                end
            end
            StConv: begin
                bcd_d = adj_bcd;
                bin_d = shifted[BINW-1:0];
                cnt_d = (cnt_q == MaxCnt) ? cnt_q : cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                end else begin
                    busy_d = 1'b1;
                end
            end
            StDone: begin
                bindata_d = bin_q;
                done_d    = 1'b1;
                state_d   = StIdle;
`ifdef BCDBIN_ERRCHK_EN
                if (errp_q) bindata_d = '0;
                err_d  = errp_q;
                errp_d = 1'b0;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            bindata_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef BCDBIN_ERRCHK_EN
            errp_q    <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            bindata_q <= bindata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef BCDBIN_ERRCHK_EN
            errp_q    <= errp_d;
            err_q     <= err_d;
`endif
        end
    end

    assign bindata = bindata_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
